// File: rtl/dct_seq_pkg.sv
// Shared widths and FSM encoding for the 8-point DCT block sequencer.
package dct_seq_pkg;

    localparam int SAMPLE_W = 8;
    localparam int COEF_W   = 12;
    localparam int BLOCK_N  = 8;
    localparam int IDX_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        FIRE,
        WAIT,
        DRAIN
    } state_t;

endpackage

// File: rtl/coef_serializer.sv
// Captures one block of DCT coefficients and streams them out, Z0 first,
// over a valid/ready handshake.
module coef_serializer
    import dct_seq_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [BLOCK_N*COEF_W-1:0] z,
    input  logic                      m_ready,
    output logic                      m_valid,
    output logic [COEF_W-1:0]         m_data,
    output logic [IDX_W-1:0]          m_index,
    output logic                      m_last,
    output logic                      done
);

    logic [BLOCK_N*COEF_W-1:0] coef_q;
    logic [IDX_W-1:0]          idx;
    logic                      valid;
    logic                      at_last;

    assign at_last = (idx == IDX_W'(BLOCK_N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_q <= '0;
        end else if (load) begin
            coef_q <= z;
        end
    end

    // The index only moves on a handshake, so output data stays put under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            idx   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            idx   <= '0;
        end else if (valid && m_ready) begin
            if (at_last) begin
                valid <= 1'b0;
                idx   <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign m_valid = valid;
    assign m_data  = coef_q[idx*COEF_W +: COEF_W];
    assign m_index = idx;
    assign m_last  = valid && at_last;
    assign done    = valid && m_ready && at_last;

endmodule

// File: rtl/dct_block_sequencer.sv
// Packs eight samples into a block, fires the DCT, waits out its latency and
// hands the captured coefficients to the serializer. One block in flight.
module dct_block_sequencer
    import dct_seq_pkg::*;
#(
    parameter int DCT_LATENCY = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [SAMPLE_W-1:0]         s_data,
    output logic [BLOCK_N*SAMPLE_W-1:0] dct_x,
    output logic                        dct_en,
    output logic                        dct_cs,
    input  logic [BLOCK_N*COEF_W-1:0]   dct_z,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [COEF_W-1:0]           m_data,
    output logic [IDX_W-1:0]            m_index,
    output logic                        m_last,
    output logic                        busy
);

    localparam int LAT_W = (DCT_LATENCY > 1) ? $clog2(DCT_LATENCY) : 1;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             accept;
    logic             lat_done;
    logic             drain_done;

    assign accept   = s_valid && s_ready;
    assign lat_done = (state == WAIT) && (lat_cnt == LAT_W'(DCT_LATENCY - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = FILL;
            FILL:  if (accept && cnt == IDX_W'(BLOCK_N - 1)) state_nx = FIRE;
            FIRE:  state_nx = WAIT;
            WAIT:  if (lat_done) state_nx = DRAIN;
            DRAIN: if (drain_done) state_nx = FILL;
            default: state_nx = IDLE;
        endcase
    end

    // IDLE lasts only the cycle after reset and reports not-busy so reset leaves every output low.
    always_comb begin
        s_ready = 1'b0;
        dct_en  = 1'b0;
        dct_cs  = 1'b0;
        busy    = 1'b1;
        case (state)
            IDLE: busy = 1'b0;
            FILL: begin
                s_ready = 1'b1;
                busy    = (cnt != '0);
            end
            FIRE: begin
                dct_en = 1'b1;
                dct_cs = 1'b1;
            end
            WAIT: dct_cs = 1'b1;
            default: ;
        endcase
    end

    // dct_x is only written on accepts, so it holds the block steady through compute and drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            dct_x <= '0;
        end else if (accept) begin
            dct_x[cnt*SAMPLE_W +: SAMPLE_W] <= s_data;
            cnt <= (cnt == IDX_W'(BLOCK_N - 1)) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= '0;
        end else if (state == WAIT && !lat_done) begin
            lat_cnt <= lat_cnt + 1'b1;
        end else begin
            lat_cnt <= '0;
        end
    end

    coef_serializer u_serializer (
        .clk     (clk),
        .rst     (rst),
        .load    (lat_done),
        .z       (dct_z),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_index (m_index),
        .m_last  (m_last),
        .done    (drain_done)
    );

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Bench for dct_block_sequencer: table of sample blocks, a latency-accurate DCT
// responder, and a scoreboard of expected coefficients checked at each handshake.
module tb_dct_block_sequencer;

    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [7:0]   s_data = '0;
    logic [63:0]  dct_x;
    logic         dct_en;
    logic         dct_cs;
    logic [95:0]  dct_z;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [11:0]  m_data;
    logic [2:0]   m_index;
    logic         m_last;
    logic         busy;

    typedef struct {
        logic [0:7][7:0] smp;
        logic [63:0]     exp_x;
    } vec_t;

    typedef struct packed {
        logic [11:0] data;
        logic [2:0]  index;
        logic        last;
    } exp_t;

    vec_t vecs [6];
    exp_t exp_q [$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int en_count = 0;
    int pop_count = 0;
    int last_count = 0;
    int last_acc_edge = 0;
    int first_hs = 0;
    int stall_cnt = 0;
    int fill_cnt = 0;
    bit pending = 1'b0;
    bit expect_ready = 1'b0;
    logic [7:0] blk [8];

    logic        prev_mv = 1'b0;
    logic        prev_mr = 1'b0;
    logic [11:0] prev_md = '0;
    logic [2:0]  prev_mi = '0;
    logic        prev_ml = 1'b0;

    logic [LAT-1:0] en_pipe;
    logic [63:0]    x_hold;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dct_block_sequencer #(.DCT_LATENCY(LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .dct_x   (dct_x),
        .dct_en  (dct_en),
        .dct_cs  (dct_cs),
        .dct_z   (dct_z),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_index (m_index),
        .m_last  (m_last),
        .busy    (busy)
    );

    // Toy transform: Z0 = sum of samples, Zk = xk*(k-4); signed, fits in 12 bits.
    function automatic logic [95:0] dct_model(input logic [63:0] x);
        int s;
        int p;
        logic [95:0] z;
        s = 0;
        z = '0;
        for (int j = 0; j < 8; j++) s += int'($signed(x[8*j +: 8]));
        z[11:0] = s[11:0];
        for (int k = 1; k < 8; k++) begin
            p = int'($signed(x[8*k +: 8])) * (k - 4);
            z[12*k +: 12] = p[11:0];
        end
        return z;
    endfunction

    // dct_z carries the result only on the cycle before capture is due; junk otherwise.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            en_pipe <= '0;
            x_hold  <= '0;
        end else begin
            en_pipe <= {en_pipe[LAT-2:0], dct_en};
            if (dct_en) x_hold <= dct_x;
        end
    end

    assign dct_z = en_pipe[LAT-1] ? dct_model(x_hold) : {8{12'hA5A}};

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int v, input int gap);
        int budget;
        for (int i = 0; i < 8; i++) begin
            budget = 0;
            s_valid = 1'b1;
            s_data  = vecs[v].smp[i];
            while (!s_ready && budget < 200) begin
                tick();
                budget++;
            end
            if (budget >= 200) checkOutput("s_ready_timeout", {63'd0, s_ready}, 64'd1);
            tick();
            s_valid = 1'b0;
            if (i < 7) for (int g = 0; g < gap; g++) tick();
        end
        if (gap == 0) begin
            checkOutput("fire_en", {63'd0, dct_en}, 64'd1);
            checkOutput("fire_busy", {63'd0, busy}, 64'd1);
            checkOutput("fire_s_ready", {63'd0, s_ready}, 64'd0);
        end
        checkOutput("dct_x_pack", dct_x, vecs[v].exp_x);
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((pending || exp_q.size() != 0 || m_valid) && b < 300) begin
            tick();
            b++;
        end
        if (b >= 300) checkOutput("drain_timeout", 64'd1, 64'd0);
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [63:0] pk;
        logic [95:0] z;
        if (rst) begin
            exp_q.delete();
            fill_cnt     = 0;
            pending      = 1'b0;
            expect_ready = 1'b0;
            stall_cnt    = 0;
            prev_mv      = 1'b0;
            prev_mr      = 1'b0;
        end else begin
            if (prev_mv && !prev_mr) begin
                checkOutput("hold_valid", {63'd0, m_valid}, 64'd1);
                checkOutput("hold_data", {52'd0, m_data}, {52'd0, prev_md});
                checkOutput("hold_index", {61'd0, m_index}, {61'd0, prev_mi});
                checkOutput("hold_last", {63'd0, m_last}, {63'd0, prev_ml});
            end
            if (expect_ready) begin
                checkOutput("s_ready_return", {63'd0, s_ready}, 64'd1);
                expect_ready = 1'b0;
            end
            if (pending) checkOutput("s_ready_busy", {63'd0, s_ready}, 64'd0);
            if (m_valid && exp_q.size() == 0) checkOutput("unexpected_valid", 64'd1, 64'd0);
            if (m_valid && !prev_mv) checkOutput("first_valid_cycle", 64'(cyc), 64'(last_acc_edge + 1 + LAT));
            if (dct_en) begin
                en_count++;
                checkOutput("dct_en_cycle", 64'(cyc), 64'(last_acc_edge));
                checkOutput("dct_cs_fire", {63'd0, dct_cs}, 64'd1);
            end
            if (m_valid && !m_ready) stall_cnt++;
            if (m_valid && m_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                pop_count++;
                if (e.index == 3'd0) begin
                    first_hs  = cyc;
                    stall_cnt = 0;
                end
                checkOutput("m_data", {52'd0, m_data}, {52'd0, e.data});
                checkOutput("m_index", {61'd0, m_index}, {61'd0, e.index});
                checkOutput("m_last", {63'd0, m_last}, {63'd0, e.last});
                if (e.last) begin
                    last_count++;
                    pending      = 1'b0;
                    expect_ready = 1'b1;
                    checkOutput("drain_span", 64'(cyc - first_hs), 64'(7 + stall_cnt));
                end
            end
            if (s_valid && s_ready) begin
                blk[fill_cnt] = s_data;
                fill_cnt++;
                if (fill_cnt == 8) begin
                    fill_cnt      = 0;
                    pending       = 1'b1;
                    last_acc_edge = cyc + 1;
                    for (int j = 0; j < 8; j++) pk[8*j +: 8] = blk[j];
                    z = dct_model(pk);
                    for (int k = 0; k < 8; k++) begin
                        e.data  = z[12*k +: 12];
                        e.index = 3'(k);
                        e.last  = (k == 7);
                        exp_q.push_back(e);
                    end
                end
            end
            prev_mv = m_valid;
            prev_mr = m_ready;
            prev_md = m_data;
            prev_mi = m_index;
            prev_ml = m_last;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int en0;
        int p0;
        int b;
        logic [11:0] d3;

        vecs[0].smp = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        vecs[0].exp_x = 64'h0807060504030201;
        vecs[1].smp = {8{8'h80}};
        vecs[1].exp_x = 64'h8080808080808080;
        vecs[2].smp = {8'h00, 8'hFF, 8'h80, 8'h7F, 8'h10, 8'hF0, 8'h01, 8'hFE};
        vecs[2].exp_x = 64'hFE01F0107F80FF00;
        vecs[3].smp = {8{8'h7F}};
        vecs[3].exp_x = 64'h7F7F7F7F7F7F7F7F;
        vecs[4].smp = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        vecs[4].exp_x = 64'h8877665544332211;
        vecs[5].smp = {8'hF9, 8'h07, 8'hC3, 8'h3C, 8'hA5, 8'h5A, 8'hE0, 8'h1F};
        vecs[5].exp_x = 64'h1FE05AA53CC307F9;

        tick();
        tick();
        checkOutput("rst_s_ready", {63'd0, s_ready}, 64'd0);
        checkOutput("rst_dct_en", {63'd0, dct_en}, 64'd0);
        checkOutput("rst_dct_cs", {63'd0, dct_cs}, 64'd0);
        checkOutput("rst_m_valid", {63'd0, m_valid}, 64'd0);
        checkOutput("rst_m_data", {52'd0, m_data}, 64'd0);
        checkOutput("rst_m_index", {61'd0, m_index}, 64'd0);
        checkOutput("rst_m_last", {63'd0, m_last}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_dct_x", dct_x, 64'd0);
        rst = 1'b0;
        tick();
        checkOutput("fill_s_ready", {63'd0, s_ready}, 64'd1);
        checkOutput("fill_busy", {63'd0, busy}, 64'd0);

        // All six blocks back to back with the sink always ready.
        m_ready = 1'b1;
        for (int v = 0; v < 6; v++) applyStimulus(v, 0);
        wait_idle();
        checkOutput("table_en_count", 64'(en_count), 64'd6);
        checkOutput("table_last_count", 64'(last_count), 64'd6);
        checkOutput("table_pop_count", 64'(pop_count), 64'd48);

        // Backpressure for five cycles on index 3.
        applyStimulus(2, 0);
        b = 0;
        while (!(m_valid && m_index == 3'd3) && b < 100) begin
            tick();
            b++;
        end
        if (b >= 100) checkOutput("idx3_timeout", 64'd1, 64'd0);
        m_ready = 1'b0;
        d3 = (exp_q.size() > 0) ? exp_q[0].data : 12'h000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_valid", {63'd0, m_valid}, 64'd1);
            checkOutput("stall_index", {61'd0, m_index}, 64'd3);
            checkOutput("stall_data", {52'd0, m_data}, {52'd0, d3});
            checkOutput("stall_s_ready", {63'd0, s_ready}, 64'd0);
        end
        m_ready = 1'b1;
        tick();
        checkOutput("release_index", {61'd0, m_index}, 64'd4);
        wait_idle();

        // s_valid toggling every other cycle.
        en0 = en_count;
        applyStimulus(3, 1);
        wait_idle();
        checkOutput("toggle_en_count", 64'(en_count - en0), 64'd1);
        checkOutput("toggle_dct_x_hold", dct_x, vecs[3].exp_x);

        // Reset while waiting on the DCT, then a fresh block.
        applyStimulus(4, 0);
        tick();
        checkOutput("wait_cs", {63'd0, dct_cs}, 64'd1);
        checkOutput("wait_en", {63'd0, dct_en}, 64'd0);
        rst = 1'b1;
        #1;
        checkOutput("abort_cs", {63'd0, dct_cs}, 64'd0);
        checkOutput("abort_m_valid", {63'd0, m_valid}, 64'd0);
        checkOutput("abort_dct_x", dct_x, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post_rst_s_ready", {63'd0, s_ready}, 64'd1);
        en0 = en_count;
        p0  = pop_count;
        applyStimulus(5, 0);
        wait_idle();
        checkOutput("post_rst_en_count", 64'(en_count - en0), 64'd1);
        checkOutput("post_rst_pop_count", 64'(pop_count - p0), 64'd8);
        repeat (5) tick();
        checkOutput("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
